// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO: start, DATA_W bits LSB first, optional parity, 1-2 stop bits.
// Define UART_TX_BREAK_EN to add the brk_req input and line-break generation.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 868,
   parameter int DATA_W       = 8,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [DATA_W-1:0]             in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
`ifdef UART_TX_BREAK_EN
   input  logic                          brk_req,
`endif
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int AW         = $clog2(FIFO_DEPTH);
   localparam int CW         = $clog2(CLKS_PER_BIT);
   localparam int FRAME_BITS = 1 + DATA_W + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS;
   localparam int BW         = $clog2(FRAME_BITS + 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

   state_t            state;
   logic [CW-1:0]     baud_cnt;
   logic [BW-1:0]     bit_idx;
   logic [DATA_W-1:0] shreg;
   logic              par_bit;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [DATA_W-1:0] head;
   logic              head_par;
   logic              push, pop, bit_end, stop_last, brk_now;

   assign in_ready  = (fifo_count != (AW+1)'(FIFO_DEPTH));
   assign push      = in_valid && in_ready;
   assign head      = mem[rd_ptr];
   assign head_par  = (^head) ^ (PARITY_MODE == 2);
   assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
   assign stop_last = bit_end && (bit_idx == BW'(STOP_BITS - 1));
`ifdef UART_TX_BREAK_EN
   assign brk_now   = brk_req;
`else
   assign brk_now   = 1'b0;
`endif

   // A word leaves the FIFO either from IDLE or straight out of the last stop bit.
   assign pop = (fifo_count != '0) &&
                (((state == IDLE) && !brk_now) || ((state == STOP) && stop_last));

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par_bit  <= 1'b0;
      end else begin
         baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_idx  <= '0;
`ifdef UART_TX_BREAK_EN
               if (brk_req) begin
                  state <= BRK;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
               end else
`endif
               if (pop) begin
                  state   <= START;
                  tx      <= 1'b0;
                  busy    <= 1'b1;
                  shreg   <= head;
                  par_bit <= head_par;
               end
            end
            START: if (bit_end) begin
               state <= DATA;
               tx    <= shreg[0];
               shreg <= shreg >> 1;
            end
            DATA: if (bit_end) begin
               if (bit_idx == BW'(DATA_W - 1)) begin
                  bit_idx <= '0;
                  if (PARITY_MODE != 0) begin
                     state <= PARITY;
                     tx    <= par_bit;
                  end else begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end
               end else begin
                  bit_idx <= bit_idx + 1'b1;
                  tx      <= shreg[0];
                  shreg   <= shreg >> 1;
               end
            end
            PARITY: if (bit_end) begin
               state <= STOP;
               tx    <= 1'b1;
            end
            STOP: if (bit_end) begin
               if (stop_last) begin
                  bit_idx <= '0;
                  if (pop) begin
                     state   <= START;
                     tx      <= 1'b0;
                     shreg   <= head;
                     par_bit <= head_par;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  bit_idx <= bit_idx + 1'b1;
               end
            end
            BRK: if (bit_end) begin
               // Hold the line low for a full frame, then reuse STOP for the high tail.
               if (bit_idx == BW'(FRAME_BITS - 1)) begin
                  bit_idx <= '0;
                  state   <= STOP;
                  tx      <= 1'b1;
               end else begin
                  bit_idx <= bit_idx + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1 main instance plus 8E1, 8O1 and 7N2 instances, all at 4 clocks/bit.
module tb_uart_tx_fifo;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready, tx, busy;
   logic [3:0] fifo_count;
`ifdef UART_TX_BREAK_EN
   logic       brk_req = 1'b0;
`endif
   logic [7:0] a_data = '0;
   logic [6:0] s_data = '0;
   logic       a_valid = 1'b0;
   logic       e_rdy, e_tx, e_busy, o_rdy, o_tx, o_busy, s_rdy, s_tx, s_busy;
   logic [3:0] e_cnt, o_cnt, s_cnt;
   int         checks = 0;
   int         errors = 0;
   logic [15:0] fr;
   int         t;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef UART_TX_BREAK_EN
      .brk_req(brk_req),
`endif
      .tx(tx), .busy(busy), .fifo_count(fifo_count));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY_MODE(1)) u_e (
      .clk(clk), .reset_n(reset_n), .in_data(a_data), .in_valid(a_valid), .in_ready(e_rdy),
`ifdef UART_TX_BREAK_EN
      .brk_req(1'b0),
`endif
      .tx(e_tx), .busy(e_busy), .fifo_count(e_cnt));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .PARITY_MODE(2)) u_o (
      .clk(clk), .reset_n(reset_n), .in_data(a_data), .in_valid(a_valid), .in_ready(o_rdy),
`ifdef UART_TX_BREAK_EN
      .brk_req(1'b0),
`endif
      .tx(o_tx), .busy(o_busy), .fifo_count(o_cnt));

   uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_W(7), .STOP_BITS(2)) u_s (
      .clk(clk), .reset_n(reset_n), .in_data(s_data), .in_valid(a_valid), .in_ready(s_rdy),
`ifdef UART_TX_BREAK_EN
      .brk_req(1'b0),
`endif
      .tx(s_tx), .busy(s_busy), .fifo_count(s_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Words 0x00.. pushed by holding in_valid through edge last_edge; nine frames expected back-to-back.
   task automatic stream(input int last_edge);
      @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h00;
      for (int n = 1; n <= 372; n++) begin
         @(posedge clk); #1;
         if (n < last_edge) in_data = 8'(n);
         else in_valid = 1'b0;
         @(negedge clk);
         if (n >= 2 && n <= 361) begin
            t  = n - 2;
            fr = {7'h00, 1'b1, 8'(t / 40), 1'b0};
            chk("stream_tx", tx, fr[(t % 40) / 4]);
            chk("stream_busy", busy, 1);
         end
         if (n == 2)   chk("stream_cnt_first_pop", fifo_count, 1);
         if (n == 9)   begin chk("stream_cnt_peak", fifo_count, 8); chk("stream_rdy_full", in_ready, 0); end
         if (n == 41)  chk("stream_rdy_before_pop", in_ready, 0);
         if (n == 42)  begin chk("stream_cnt_after_pop", fifo_count, 7); chk("stream_rdy_after_pop", in_ready, 1); end
         if (n == 362) begin
            chk("stream_end_tx", tx, 1);
            chk("stream_end_busy", busy, 0);
            chk("stream_end_cnt", fifo_count, 0);
         end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", fifo_count, 0);
      chk("rst_rdy", in_ready, 1);

      // 8N1 0xA5
      @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hA5;
      @(posedge clk); #1 in_valid = 1'b0; in_data = 8'h3C;
      @(negedge clk);
      chk("t1_cnt_push", fifo_count, 1);
      chk("t1_tx_before", tx, 1);
      chk("t1_busy_before", busy, 0);
      @(posedge clk);
      fr = {6'h00, 1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("t1_tx", tx, fr[i / 4]);
         chk("t1_busy", busy, 1);
         if (i == 0) chk("t1_cnt_pop", fifo_count, 0);
      end
      @(negedge clk);
      chk("t1_idle_tx", tx, 1);
      chk("t1_idle_busy", busy, 0);

      // 8E1 / 8O1 with 0xA5 and 7N2 with 0x7F, pushed on the same edge
      @(posedge clk); #1 a_valid = 1'b1; a_data = 8'hA5; s_data = 7'h7F;
      @(posedge clk); #1 a_valid = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 44; i++) begin
         @(negedge clk);
         fr = {5'h00, 1'b1, 1'b0, 8'hA5, 1'b0};
         chk("t2_even_tx", e_tx, fr[i / 4]);
         chk("t2_even_busy", e_busy, 1);
         fr = {5'h00, 1'b1, 1'b1, 8'hA5, 1'b0};
         chk("t2_odd_tx", o_tx, fr[i / 4]);
         fr = {6'h00, 2'b11, 7'h7F, 1'b0};
         chk("t2_7n2_tx", s_tx, (i < 40) ? fr[i / 4] : 1'b1);
         chk("t2_7n2_busy", s_busy, (i < 40) ? 1 : 0);
      end
      @(negedge clk);
      chk("t2_even_done", e_busy, 0);
      chk("t2_odd_done", o_busy, 0);
      chk("t2_odd_idle_tx", o_tx, 1);

      // Continuous push, then push while full with a simultaneous pop
      stream(12);
      stream(42);

      // Reset in the middle of the second of three queued frames
      @(posedge clk); #1 in_valid = 1'b1; in_data = 8'h11;
      @(posedge clk); #1 in_data = 8'h22;
      @(posedge clk); #1 in_data = 8'h33;
      @(posedge clk); #1 in_valid = 1'b0;
      for (int n = 4; n <= 49; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (n == 44) chk("t4_start2_tx", tx, 0);
         if (n == 45) begin chk("t4_cnt", fifo_count, 1); chk("t4_busy", busy, 1); end
         if (n == 47) chk("t4_data2_bit0", tx, 0);
         if (n == 49) chk("t4_data2_bit0_end", tx, 0);
      end
      reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      chk("t4_rst_tx", tx, 1);
      chk("t4_rst_busy", busy, 0);
      chk("t4_rst_cnt", fifo_count, 0);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         chk("t4_quiet", {busy, tx}, 2'b01);
      end

`ifdef UART_TX_BREAK_EN
      // Break requested in IDLE on the same edge 0x55 is pushed
      @(posedge clk); #1 brk_req = 1'b1; in_valid = 1'b1; in_data = 8'h55;
      @(posedge clk); #1 brk_req = 1'b0; in_valid = 1'b0;
      fr = {6'h00, 1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 84; i++) begin
         @(negedge clk);
         if (i == 0) chk("t6_cnt", fifo_count, 1);
         chk("t6_tx", tx, (i < 40) ? 1'b0 : (i < 44) ? 1'b1 : fr[(i - 44) / 4]);
         chk("t6_busy", busy, 1);
      end
      @(negedge clk);
      chk("t6_idle", {busy, tx}, 2'b01);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
